// File: rtl/sm_key_entry.sv
// sm_key_entry: debounced hex key entry that assembles a 32-bit word and writes it over valid/ready
//   clk, rst             : clock, synchronous active-high reset
//   keyRaw[2:0]          : raw active-low buttons: [0] digit, [1] commit, [2] clear
//   swNibble[3:0]        : hex digit shifted in on a digit event
//   value, digitCount    : word assembled so far and digits entered (saturates at 8)
//   busy                 : high while a write is pending
//   wrValid/wrData/wrReady : write port, transfer on wrValid && wrReady
module sm_key_entry #(
    parameter int DB_CYCLES = 500000,
    parameter int DB_W      = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  keyRaw,
    input  logic [3:0]  swNibble,
    output logic [31:0] value,
    output logic [3:0]  digitCount,
    output logic        busy,
    output logic        wrValid,
    output logic [31:0] wrData,
    input  logic        wrReady
);
    typedef enum logic [1:0] {IDLE, ENTRY, SEND} state_t;
    localparam logic [DB_W-1:0] LAST = DB_W'(DB_CYCLES - 1);
    state_t state, state_n;
    logic [2:0] s1, s2, deb, deb_d, ev;
    logic [DB_W-1:0] cnt [3];
    logic [31:0] value_n, data_n;
    logic [3:0] count_n;
    logic valid_n, dig, com, clr;
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 3'b111;
            s2 <= 3'b111;
            deb <= 3'b111;
            deb_d <= 3'b111;
            ev <= 3'b000;
            for (int k = 0; k < 3; k++) cnt[k] <= '0;
        end else begin
            s1 <= keyRaw;
            s2 <= s1;
            deb_d <= deb;
            // press pulse lags the debounced edge by one register stage
            ev <= deb_d & ~deb;
            for (int k = 0; k < 3; k++) begin
                if (s2[k] != deb[k]) begin
                    if (cnt[k] == LAST) begin
                        deb[k] <= s2[k];
                        cnt[k] <= '0;
                    end else begin
                        cnt[k] <= cnt[k] + DB_W'(1);
                    end
                end else begin
                    cnt[k] <= '0;
                end
            end
        end
    end
    // clear outranks commit, which outranks digit
    assign clr = ev[2];
    assign com = ev[1] & ~ev[2];
    assign dig = ev[0] & ~ev[1] & ~ev[2];
    assign busy = (state == SEND);
    always_comb begin
        state_n = state;
        value_n = value;
        count_n = digitCount;
        valid_n = wrValid;
        data_n  = wrData;
        case (state)
            IDLE: if (dig) begin
                value_n = {value[27:0], swNibble};
                count_n = 4'd1;
                state_n = ENTRY;
            end
            ENTRY: if (clr) begin
                value_n = '0;
                count_n = '0;
                state_n = IDLE;
            end else if (com) begin
                data_n  = value;
                valid_n = 1'b1;
                state_n = SEND;
            end else if (dig) begin
                value_n = {value[27:0], swNibble};
                count_n = (digitCount == 4'd8) ? 4'd8 : digitCount + 4'd1;
            end
            SEND: if (wrReady) begin
                valid_n = 1'b0;
                value_n = '0;
                count_n = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            value <= '0;
            digitCount <= '0;
            wrValid <= 1'b0;
            wrData <= '0;
        end else begin
            state <= state_n;
            value <= value_n;
            digitCount <= count_n;
            wrValid <= valid_n;
            wrData <= data_n;
        end
    end
endmodule

// File: tb/tb_sm_key_entry.sv
// tb_sm_key_entry: directed vector bench for sm_key_entry with DB_CYCLES=4
module tb_sm_key_entry;
    logic clk = 0, rst = 1, wrReady = 0;
    logic [2:0] keyRaw = 3'b111;
    logic [3:0] swNibble = 0;
    logic [31:0] value, wrData;
    logic [3:0] digitCount;
    logic busy, wrValid;
    int total = 0, bad = 0, wv_cnt = 0;

    sm_key_entry #(.DB_CYCLES(4), .DB_W(3)) dut (
        .clk(clk), .rst(rst), .keyRaw(keyRaw), .swNibble(swNibble),
        .value(value), .digitCount(digitCount), .busy(busy),
        .wrValid(wrValid), .wrData(wrData), .wrReady(wrReady)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  m;
        logic [3:0]  sw;
        logic [31:0] v;
        logic [3:0]  c;
        logic        b;
        int          wv;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] m, input logic [3:0] sw);
        wv_cnt = 0;
        swNibble = sw;
        keyRaw = ~m;
        repeat (20) begin @(negedge clk); if (wrValid) wv_cnt++; end
        keyRaw = 3'b111;
        repeat (12) begin @(negedge clk); if (wrValid) wv_cnt++; end
    endtask

    task automatic run_row(input int i);
        press(tbl[i].m, tbl[i].sw);
        chk($sformatf("row%0d value", i), value, tbl[i].v);
        chk($sformatf("row%0d count", i), {28'd0, digitCount}, {28'd0, tbl[i].c});
        chk($sformatf("row%0d busy", i), {31'd0, busy}, {31'd0, tbl[i].b});
        chk($sformatf("row%0d wvcnt", i), wv_cnt, tbl[i].wv);
    endtask

    initial begin
        int hc;
        logic data_ok;
        tbl[0]  = '{3'b001, 4'hA, 32'h0000000A, 4'd1, 1'b0, 0};
        tbl[1]  = '{3'b001, 4'h5, 32'h000000A5, 4'd2, 1'b0, 0};
        tbl[2]  = '{3'b100, 4'h0, 32'h00000000, 4'd0, 1'b0, 0};
        tbl[3]  = '{3'b001, 4'h1, 32'h00000001, 4'd1, 1'b0, 0};
        tbl[4]  = '{3'b001, 4'h2, 32'h00000012, 4'd2, 1'b0, 0};
        tbl[5]  = '{3'b001, 4'h3, 32'h00000123, 4'd3, 1'b0, 0};
        tbl[6]  = '{3'b001, 4'h4, 32'h00001234, 4'd4, 1'b0, 0};
        tbl[7]  = '{3'b001, 4'h5, 32'h00012345, 4'd5, 1'b0, 0};
        tbl[8]  = '{3'b001, 4'h6, 32'h00123456, 4'd6, 1'b0, 0};
        tbl[9]  = '{3'b001, 4'h7, 32'h01234567, 4'd7, 1'b0, 0};
        tbl[10] = '{3'b001, 4'h8, 32'h12345678, 4'd8, 1'b0, 0};
        tbl[11] = '{3'b001, 4'h9, 32'h23456789, 4'd8, 1'b0, 0};
        tbl[12] = '{3'b100, 4'h0, 32'h00000000, 4'd0, 1'b0, 0};
        tbl[13] = '{3'b010, 4'h0, 32'h00000000, 4'd0, 1'b0, 0};
        tbl[14] = '{3'b001, 4'h3, 32'h00000003, 4'd1, 1'b0, 0};
        tbl[15] = '{3'b110, 4'h0, 32'h00000000, 4'd0, 1'b0, 0};
        tbl[16] = '{3'b001, 4'hB, 32'h0000000B, 4'd1, 1'b0, 0};

        repeat (3) @(negedge clk);
        chk("rst value", value, 0);
        chk("rst count", {28'd0, digitCount}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst wrValid", {31'd0, wrValid}, 0);
        chk("rst wrData", wrData, 0);
        rst = 0;

        run_row(0);
        run_row(1);

        // commit with wrReady low for 10 valid cycles, then high
        hc = 0;
        data_ok = 1;
        keyRaw = 3'b101;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (wrValid) begin
                hc++;
                keyRaw = 3'b111;
                if (wrData !== 32'hA5 || !busy) data_ok = 0;
                if (hc == 11) wrReady = 1;
            end else if (hc > 0) begin
                break;
            end
        end
        wrReady = 0;
        keyRaw = 3'b111;
        chk("send cycles", hc, 11);
        chk("send data stable", {31'd0, data_ok}, 1);
        chk("post send wrValid", {31'd0, wrValid}, 0);
        chk("post send value", value, 0);
        chk("post send count", {28'd0, digitCount}, 0);
        chk("post send busy", {31'd0, busy}, 0);
        repeat (12) @(negedge clk);

        // bounce shorter than the debounce window is ignored
        swNibble = 4'h7;
        keyRaw = 3'b110; repeat (3) @(negedge clk);
        keyRaw = 3'b111; repeat (3) @(negedge clk);
        keyRaw = 3'b110; repeat (3) @(negedge clk);
        keyRaw = 3'b111; repeat (12) @(negedge clk);
        chk("bounce value", value, 0);
        chk("bounce count", {28'd0, digitCount}, 0);
        press(3'b001, 4'h7);
        chk("held value", value, 32'h7);
        chk("held count", {28'd0, digitCount}, 1);

        for (int i = 2; i < 17; i++) run_row(i);

        // keys ignored in SEND, reset aborts the write
        press(3'b010, 4'h0);
        chk("send wrValid", {31'd0, wrValid}, 1);
        chk("send wrData", wrData, 32'hB);
        chk("send busy", {31'd0, busy}, 1);
        press(3'b001, 4'hE);
        press(3'b100, 4'h0);
        chk("ignored wrValid", {31'd0, wrValid}, 1);
        chk("ignored wrData", wrData, 32'hB);
        chk("ignored value", value, 32'hB);
        chk("ignored count", {28'd0, digitCount}, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("abort wrValid", {31'd0, wrValid}, 0);
        chk("abort value", value, 0);
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort count", {28'd0, digitCount}, 0);

        // ready already high: single-cycle transfer
        wrReady = 1;
        press(3'b001, 4'hC);
        chk("restart value", value, 32'hC);
        press(3'b010, 4'h0);
        chk("fast wvcnt", wv_cnt, 1);
        chk("fast value", value, 0);
        chk("fast busy", {31'd0, busy}, 0);
        wrReady = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
